step_pattern_monitor: RTL

- Downstream checker for the 4-bit increment/hold pattern counter; samples its output value every enabled cycle.
- Classifies each step as increment, hold or illegal.
- Locks onto the periodic pattern of INC_RUN increments followed by HOLD_RUN holds.
- Flags deviations with a pulse and a saturating error count; used as an in-design health monitor and a bench scoreboard.

---
 rtl/step_pattern_monitor.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/step_pattern_monitor.sv
// rtl/step_pattern_monitor.sv - lock onto and police an increment/hold counter pattern
module step_pattern_monitor #(
    parameter int WIDTH    = 4,
    parameter int INC_RUN  = 3,
    parameter int HOLD_RUN = 1,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic             locked,
    output logic             step_inc,
    output logic             step_hold,
    output logic             wrap_pulse,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    // Run counters need to reach the larger run length plus one spare value so
    // an over-long hold run in SEEK can saturate without aliasing HOLD_RUN.
    localparam int CMAX = ((INC_RUN > HOLD_RUN) ? INC_RUN : HOLD_RUN) + 1;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] INC_N  = CW'(INC_RUN);
    localparam logic [CW-1:0] HOLD_N = CW'(HOLD_RUN);
    localparam logic [CW-1:0] SAT_N  = CW'(CMAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] prev, prev_n;
    logic             have_prev, have_prev_n;
    logic [CW-1:0]    inc_cnt, inc_cnt_n;
    logic [CW-1:0]    hold_cnt, hold_cnt_n;

    logic             locked_n, inc_n, hold_n, wrap_n, errp_n;
    logic [ERR_W-1:0] err_cnt_n;
    logic [WIDTH-1:0] delta;
    logic             is_inc, is_hold, expect_inc;

    // Classify the step and compute the next state and registered outputs.
    always_comb begin
        state_n     = state;
        prev_n      = prev;
        have_prev_n = have_prev;
        inc_cnt_n   = inc_cnt;
        hold_cnt_n  = hold_cnt;
        locked_n    = locked;
        err_cnt_n   = err_cnt;
        inc_n       = 1'b0;
        hold_n      = 1'b0;
        wrap_n      = 1'b0;
        errp_n      = 1'b0;
        expect_inc  = 1'b0;

        delta   = din - prev;
        is_inc  = (delta == WIDTH'(1));
        is_hold = (delta == '0);

        if (en) begin
            prev_n      = din;
            have_prev_n = 1'b1;

            // Step pulses only exist once there is a previous value to diff against.
            if (have_prev) begin
                inc_n  = is_inc;
                hold_n = is_hold;
                wrap_n = is_inc && (prev == '1) && (din == '0);
            end

            case (state)
                IDLE: begin
                    state_n    = SEEK;
                    inc_cnt_n  = '0;
                    hold_cnt_n = '0;
                end
                SEEK: begin
                    if (is_hold) begin
                        if (hold_cnt != SAT_N)
                            hold_cnt_n = hold_cnt + CW'(1);
                    end else if (is_inc && hold_cnt == HOLD_N) begin
                        state_n    = LOCK;
                        locked_n   = 1'b1;
                        inc_cnt_n  = CW'(1);
                        hold_cnt_n = '0;
                    end else begin
                        hold_cnt_n = '0;
                    end
                end
                LOCK: begin
                    // INC is due while the run is short, or once the hold run is complete.
                    expect_inc = (inc_cnt < INC_N) || (hold_cnt == HOLD_N);
                    if (is_inc && expect_inc) begin
                        if (hold_cnt == HOLD_N) begin
                            inc_cnt_n  = CW'(1);
                            hold_cnt_n = '0;
                        end else begin
                            inc_cnt_n = inc_cnt + CW'(1);
                        end
                    end else if (is_hold && !expect_inc) begin
                        hold_cnt_n = hold_cnt + CW'(1);
                    end else begin
                        errp_n     = 1'b1;
                        err_cnt_n  = (&err_cnt) ? err_cnt : err_cnt + ERR_W'(1);
                        locked_n   = 1'b0;
                        state_n    = SEEK;
                        // A stray hold can itself be the hold that precedes realignment.
                        hold_cnt_n = is_hold ? CW'(1) : '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prev       <= '0;
            have_prev  <= 1'b0;
            inc_cnt    <= '0;
            hold_cnt   <= '0;
            locked     <= 1'b0;
            step_inc   <= 1'b0;
            step_hold  <= 1'b0;
            wrap_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state      <= state_n;
            prev       <= prev_n;
            have_prev  <= have_prev_n;
            inc_cnt    <= inc_cnt_n;
            hold_cnt   <= hold_cnt_n;
            locked     <= locked_n;
            step_inc   <= inc_n;
            step_hold  <= hold_n;
            wrap_pulse <= wrap_n;
            err_pulse  <= errp_n;
            err_cnt    <= err_cnt_n;
        end
    end

endmodule
